tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter.sv | 117 +++++++++++
 tb/tb_tx_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// Three-source frame arbiter feeding a single tx link through a one-word output slot.
// tr has strict priority; ch1/ch2 share a round-robin pointer that advances on channel frame ends.
module tx_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tr_data,
    input  logic [DATA_WIDTH-1:0] ch1_data,
    input  logic [DATA_WIDTH-1:0] ch2_data,
    input  logic                  tr_rdy,
    input  logic                  ch1_rdy,
    input  logic                  ch2_rdy,
    input  logic                  tr_eof,
    input  logic                  ch1_eof,
    input  logic                  ch2_eof,
    output logic                  tr_ack,
    output logic                  ch1_ack,
    output logic                  ch2_ack,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_rdy,
    output logic                  tx_eof,
    input  logic                  tx_ack,
    output logic [1:0]            src_id,
    output logic                  busy,
    output logic                  trunc
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t                state;
    logic                  ptr;   // 0: ch1 wins a ch1/ch2 tie
    logic [CW-1:0]         cnt;
    logic                  sel_rdy;
    logic                  sel_eof;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [1:0]            grant;
    logic                  slot_free;
    logic                  xfer;
    logic                  last;
    logic                  frame_end;

    always_comb begin
        sel_rdy  = tr_rdy;
        sel_eof  = tr_eof;
        sel_data = tr_data;
        if (src_id == 2'd1) begin
            sel_rdy  = ch1_rdy;
            sel_eof  = ch1_eof;
            sel_data = ch1_data;
        end else if (src_id == 2'd2) begin
            sel_rdy  = ch2_rdy;
            sel_eof  = ch2_eof;
            sel_data = ch2_data;
        end
    end

    always_comb begin
        grant = 2'd2;
        if (tr_rdy)
            grant = 2'd0;
        else if (ch1_rdy && ch2_rdy)
            grant = ptr ? 2'd2 : 2'd1;
        else if (ch1_rdy)
            grant = 2'd1;
    end

    assign busy      = (state == ST_GRANT);
    // The slot can take a new word whenever it is empty or being drained this cycle.
    assign slot_free = !tx_rdy || tx_ack;
    assign xfer      = busy && sel_rdy && slot_free;
    assign tr_ack    = xfer && (src_id == 2'd0);
    assign ch1_ack   = xfer && (src_id == 2'd1);
    assign ch2_ack   = xfer && (src_id == 2'd2);
    assign last      = (cnt == CW'(MAX_WORDS - 1));
    assign frame_end = sel_eof || last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= 1'b0;
            cnt     <= '0;
            src_id  <= 2'd0;
            tx_data <= '0;
            tx_rdy  <= 1'b0;
            tx_eof  <= 1'b0;
            trunc   <= 1'b0;
        end else begin
            trunc <= 1'b0;
            if (tx_rdy && tx_ack) begin
                tx_rdy <= 1'b0;
                tx_eof <= 1'b0;
            end
            if (state == ST_IDLE) begin
                if (tr_rdy || ch1_rdy || ch2_rdy) begin
                    src_id <= grant;
                    cnt    <= '0;
                    state  <= ST_GRANT;
                end
            end else if (xfer) begin
                tx_data <= sel_data;
                tx_rdy  <= 1'b1;
                tx_eof  <= frame_end;
                cnt     <= cnt + 1'b1;
                if (frame_end) begin
                    state <= ST_IDLE;
                    trunc <= !sel_eof;
                    if (src_id != 2'd0)
                        ptr <= ~ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomized bench for tx_arbiter: queue-driven sources, a frame-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_tx_arbiter;
    localparam int DW   = 8;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data [3] = '{8'h0, 8'h0, 8'h0};
    logic          rdy  [3] = '{1'b0, 1'b0, 1'b0};
    logic          eof  [3] = '{1'b0, 1'b0, 1'b0};
    logic          ack  [3];
    logic [DW-1:0] tx_data;
    logic          tx_rdy, tx_eof, busy, trunc;
    logic          tx_ack = 1'b0;
    logic [1:0]    src_id;

    tx_arbiter #(.DATA_WIDTH(DW), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst),
        .tr_data(data[0]), .ch1_data(data[1]), .ch2_data(data[2]),
        .tr_rdy(rdy[0]), .ch1_rdy(rdy[1]), .ch2_rdy(rdy[2]),
        .tr_eof(eof[0]), .ch1_eof(eof[1]), .ch2_eof(eof[2]),
        .tr_ack(ack[0]), .ch1_ack(ack[1]), .ch2_ack(ack[2]),
        .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_eof(tx_eof), .tx_ack(tx_ack),
        .src_id(src_id), .busy(busy), .trunc(trunc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Source feeder: each source presents the head of its word queue {eof,data}.
    logic [8:0]  sq [3][$];
    int unsigned ack_prob = 100;
    int unsigned rdy_prob = 100;
    bit          rand_on  = 1'b0;
    bit          xf [3]   = '{1'b0, 1'b0, 1'b0};

    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (xf[i] && sq[i].size() > 0)
                void'(sq[i].pop_front());
            if (rand_on && sq[i].size() == 0 && $urandom_range(3) == 0) begin
                int unsigned n;
                n = $urandom_range(6, 1);
                for (int unsigned k = 0; k < n; k++)
                    sq[i].push_back({k == n - 1, 8'($urandom)});
            end
            rdy[i] = (sq[i].size() > 0) && ($urandom_range(99) < rdy_prob);
            {eof[i], data[i]} = (sq[i].size() > 0) ? sq[i][0] : 9'h0;
        end
        tx_ack = $urandom_range(99) < ack_prob;
    end

    // Reference model: who owns the link, how many words of the frame went out,
    // and what sits in the one-word slot.
    bit          m_busy, m_ptr, m_full, m_eof, m_trunc;
    int          m_src, m_cnt;
    logic [7:0]  m_data;
    logic [8:0]  outl [$];
    int          grl  [$];
    int          ntrunc = 0;
    bit          pbusy  = 1'b0;

    always @(negedge clk) begin
        bit e_ack [3];
        bit drain;
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_full = 0; m_eof = 0; m_trunc = 0;
            m_src = 0; m_cnt = 0; m_data = 0; pbusy = 0;
            for (int i = 0; i < 3; i++) begin
                xf[i] = 0;
                chk($sformatf("rst_ack%0d", i), 32'(ack[i]), 0);
            end
            chk("rst_tx_rdy", 32'(tx_rdy), 0);
            chk("rst_tx_eof", 32'(tx_eof), 0);
            chk("rst_tx_data", 32'(tx_data), 0);
            chk("rst_src_id", 32'(src_id), 0);
            chk("rst_trunc", 32'(trunc), 0);
            chk("rst_busy", 32'(busy), 0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                e_ack[i] = m_busy && m_src == i && rdy[i] && (!m_full || tx_ack);
                chk($sformatf("ack%0d", i), 32'(ack[i]), 32'(e_ack[i]));
            end
            chk("tx_rdy", 32'(tx_rdy), 32'(m_full));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("trunc", 32'(trunc), 32'(m_trunc));
            if (m_busy) chk("src_id", 32'(src_id), m_src);
            if (m_full) begin
                chk("tx_data", 32'(tx_data), 32'(m_data));
                chk("tx_eof", 32'(tx_eof), 32'(m_eof));
            end
            if (tx_rdy && tx_ack) outl.push_back({tx_eof, tx_data});
            if (busy && !pbusy) grl.push_back(int'(src_id));
            if (trunc) ntrunc++;
            pbusy = busy;
            for (int i = 0; i < 3; i++) xf[i] = rdy[i] && ack[i];

            drain   = m_full && tx_ack;
            m_trunc = 0;
            if (drain) m_full = 0;
            if (!m_busy) begin
                if (rdy[0] || rdy[1] || rdy[2]) begin
                    m_busy = 1;
                    m_cnt  = 0;
                    m_src  = rdy[0] ? 0 : (rdy[1] && rdy[2]) ? (m_ptr ? 2 : 1) : (rdy[1] ? 1 : 2);
                end
            end else if (e_ack[m_src]) begin
                m_cnt++;
                m_full = 1;
                m_data = data[m_src];
                m_eof  = eof[m_src] || m_cnt == MAXW;
                if (m_eof) begin
                    m_trunc = !eof[m_src];
                    m_busy  = 0;
                    if (m_src != 0) m_ptr = !m_ptr;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_out(input int n, input int budget, input string nm);
        int k = 0;
        while (outl.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (outl.size() < n) chk(nm, outl.size(), n);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        while ((sq[0].size() + sq[1].size() + sq[2].size() > 0 || busy || tx_rdy) && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 32'(busy || tx_rdy), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) sq[i].delete();
        @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        int b, g, k, nt, ntr;
        int chs [$];
        logic [8:0] exp34 [6];

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;

        // tr beats ch1 on a simultaneous request; ch1 follows
        b = outl.size(); g = grl.size();
        sq[0].push_back({1'b0, 8'hA1});
        sq[0].push_back({1'b1, 8'hA2});
        sq[1].push_back({1'b1, 8'h11});
        wait_out(b + 3, 40, "t032_wait");
        chk("t032_w0", 32'(outl[b]), 32'({1'b0, 8'hA1}));
        chk("t032_w1", 32'(outl[b+1]), 32'({1'b1, 8'hA2}));
        chk("t032_w2", 32'(outl[b+2]), 32'({1'b1, 8'h11}));
        chk("t032_g0", grl[g], 0);
        chk("t032_g1", grl[g+1], 1);
        wait_idle(40, "t032_idle");

        // reset mid-frame clears everything at once; pointer returns to ch1
        sq[1].push_back({1'b0, 8'hC1});
        sq[1].push_back({1'b0, 8'hC2});
        sq[1].push_back({1'b1, 8'hC3});
        k = 0;
        while (!tx_rdy && k < 20) begin tick(); k++; end
        @(posedge clk);
        #1;
        chk("t037_pre_busy", 32'(busy), 1);
        chk("t037_pre_tx_rdy", 32'(tx_rdy), 1);
        chk("t037_pre_ack1", 32'(ack[1]), 1);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) sq[i].delete();
        #1;
        chk("t037_tx_rdy", 32'(tx_rdy), 0);
        chk("t037_busy", 32'(busy), 0);
        chk("t037_ack1", 32'(ack[1]), 0);
        @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        b = outl.size(); g = grl.size();
        sq[1].push_back({1'b1, 8'h31});
        sq[2].push_back({1'b1, 8'h41});
        wait_out(b + 2, 40, "t037_wait");
        chk("t037_g0", grl[g], 1);
        chk("t037_g1", grl[g+1], 2);
        chk("t037_w0", 32'(outl[b]), 32'({1'b1, 8'h31}));
        wait_idle(40, "t037_idle");

        // ch1/ch2 alternate; tr frames jump in without disturbing the alternation
        b = outl.size(); g = grl.size();
        sq[0].push_back({1'b1, 8'h0F});
        for (int i = 0; i < 4; i++) begin
            sq[1].push_back({1'b1, 8'(8'h10 + i)});
            sq[2].push_back({1'b1, 8'(8'h20 + i)});
        end
        wait_out(b + 4, 40, "t033_wait_a");
        sq[0].push_back({1'b1, 8'h0E});
        wait_out(b + 10, 80, "t033_wait_b");
        ntr = 0;
        for (int i = g; i < grl.size(); i++) begin
            if (grl[i] == 0) ntr++;
            else chs.push_back(grl[i]);
        end
        chk("t033_tr_grants", ntr, 2);
        chk("t033_ch_grants", chs.size(), 8);
        for (int i = 0; i < chs.size(); i++)
            chk($sformatf("t033_alt%0d", i), chs[i], (i % 2) ? 2 : 1);
        wait_idle(40, "t033_idle");

        // back-to-back words stream at one per cycle, one cycle after each ack
        for (int i = 0; i < 4; i++) sq[1].push_back({i == 3, 8'(8'hD0 + i)});
        k = 0;
        while (!(rdy[1] && ack[1]) && k < 20) begin tick(); k++; end
        chk("t035_first_ack", 32'(ack[1]), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t035_rdy%0d", i), 32'(tx_rdy), 1);
            chk($sformatf("t035_data%0d", i), 32'(tx_data), 32'(8'hD0 + i));
            chk($sformatf("t035_eof%0d", i), 32'(tx_eof), 32'(i == 3));
        end
        wait_idle(40, "t035_idle");

        // stalled link: slot holds, source is not acked; release refills in the same cycle
        ack_prob = 0;
        sq[1].push_back({1'b0, 8'hB1});
        sq[1].push_back({1'b0, 8'hB2});
        sq[1].push_back({1'b1, 8'hB3});
        k = 0;
        while (!tx_rdy && k < 20) begin tick(); k++; end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t036_hold%0d", i), 32'(tx_data), 32'(8'hB1));
            chk($sformatf("t036_noack%0d", i), 32'(ack[1]), 0);
        end
        ack_prob = 100;
        tick();
        chk("t036_ack_refill", 32'({ack[1], tx_ack}), 32'(2'b11));
        tick();
        chk("t036_next", 32'(tx_data), 32'(8'hB2));
        wait_idle(40, "t036_idle");

        // truncation at MAXW, remainder forms a new frame that then waits on its source
        b = outl.size(); g = grl.size(); nt = ntrunc;
        for (int i = 0; i < 6; i++) sq[2].push_back({1'b0, 8'(8'h51 + i)});
        exp34 = '{9'h051, 9'h052, 9'h053, 9'h154, 9'h055, 9'h056};
        wait_out(b + 6, 60, "t034_wait");
        for (int i = 0; i < 6; i++)
            chk($sformatf("t034_w%0d", i), 32'(outl[b+i]), 32'(exp34[i]));
        chk("t034_trunc_count", ntrunc - nt, 1);
        chk("t034_g0", grl[g], 2);
        chk("t034_g1", grl[g+1], 2);
        sq[0].push_back({1'b1, 8'h77});
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t034_hold_busy%0d", i), 32'(busy), 1);
            chk($sformatf("t034_hold_src%0d", i), 32'(src_id), 2);
            chk($sformatf("t034_no_tr%0d", i), 32'(ack[0]), 0);
        end
        do_reset();

        // random traffic, link backpressure and source gaps
        rand_on = 1'b1;
        rdy_prob = 75;
        for (int r = 0; r < 6; r++) begin
            ack_prob = $urandom_range(100, 30);
            repeat (500) @(negedge clk);
        end
        rand_on = 1'b0;
        rdy_prob = 100;
        ack_prob = 100;
        wait_idle(600, "rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
